// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: FSM state type and
// derivation of offset and way-select widths from the geometry parameters.
package cache_miss_ctrl_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSEL,
    S_VREAD,
    S_WB,
    S_RREQ,
    S_RECV,
    S_FILL
  } state_e;

  function automatic int unsigned off_len(input int unsigned line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int unsigned way_bits(input int unsigned way);
    return $clog2(way);
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: per-set round-robin counters or a free-running
// 16-bit Fibonacci LFSR, chosen by REPL_MODE.
module cache_victim_sel
  import cache_miss_ctrl_pkg::*;
#(
  parameter int unsigned WAY       = 2,
  parameter int unsigned INDEXLEN  = 8,
  parameter int unsigned REPL_MODE = 0,
  localparam int unsigned WB       = way_bits(WAY),
  localparam int unsigned SETS     = 1 << INDEXLEN
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [INDEXLEN-1:0] idx,
  input  logic                adv,
  output logic [WB-1:0]       way
);

  logic [WB-1:0] rr_q [SETS];
  logic [15:0]   lfsr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        rr_q[i] <= '0;
      end
      lfsr_q <= 16'h0001;
    end else begin
      // taps 16,14,13,11 map to bits 15,13,12,10
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (adv) begin
        rr_q[idx] <= rr_q[idx] + WB'(1);
      end
    end
  end

  assign way = (REPL_MODE != 0) ? lfsr_q[WB-1:0] : rr_q[idx];

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: picks a victim, writes it back if dirty, fetches the
// missing line beat by beat and issues a single-cycle fill.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int unsigned WAY        = 2,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned INDEXLEN   = 8,
  parameter int unsigned TAGLEN     = 20,
  parameter int unsigned REPL_MODE  = 0,
  localparam int unsigned OFFLEN    = off_len(LINE_WORDS),
  localparam int unsigned WB        = way_bits(WAY),
  localparam int unsigned LINE_W    = WORD_W * LINE_WORDS,
  localparam int unsigned BW        = $clog2(LINE_WORDS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [INDEXLEN-1:0] miss_idx,
  input  logic [TAGLEN-1:0]   miss_tag,
  output logic                vic_rd_en,
  output logic [WB-1:0]       vic_way,
  output logic [INDEXLEN-1:0] vic_idx,
  input  logic                vic_v,
  input  logic                vic_d,
  input  logic [TAGLEN-1:0]   vic_tag,
  input  logic [LINE_W-1:0]   vic_data,
  output logic                wr_req,
  input  logic                wr_rdy,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [LINE_W-1:0]   wr_data,
  output logic                rd_req,
  input  logic                rd_rdy,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [WORD_W-1:0]   ret_data,
  output logic                fill_we,
  output logic [WB-1:0]       fill_way,
  output logic [INDEXLEN-1:0] fill_idx,
  output logic [TAGLEN-1:0]   fill_tag,
  output logic [LINE_W-1:0]   fill_data,
  output logic                done,
  output logic                err
);

  state_e                               state_q;
  logic [INDEXLEN-1:0]                  idx_q;
  logic [TAGLEN-1:0]                    tag_q;
  logic [TAGLEN-1:0]                    vtag_q;
  logic [WB-1:0]                        way_q;
  logic [LINE_W-1:0]                    vdata_q;
  logic [LINE_WORDS-1:0][WORD_W-1:0]    buf_q;
  logic [BW-1:0]                        beat_q;
  logic                                 err_q;
  logic                                 ign_q;

  logic [INDEXLEN-1:0] vs_idx;
  logic                vs_adv;
  logic [WB-1:0]       vs_way;

  // The selector looks up the incoming set while idle and advances the
  // latched set during the fill.
  assign vs_adv = (state_q == S_FILL);
  assign vs_idx = vs_adv ? idx_q : miss_idx;

  cache_victim_sel #(
    .WAY      (WAY),
    .INDEXLEN (INDEXLEN),
    .REPL_MODE(REPL_MODE)
  ) u_victim_sel (
    .clk   (clk),
    .resetn(resetn),
    .idx   (vs_idx),
    .adv   (vs_adv),
    .way   (vs_way)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
      vdata_q <= '0;
      buf_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      ign_q   <= 1'b1;
    end else begin
      // beats still in flight from an aborted miss are dropped silently
      if (ret_valid && state_q != S_RECV && !ign_q) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (miss_valid) begin
            idx_q   <= miss_idx;
            tag_q   <= miss_tag;
            way_q   <= vs_way;
            beat_q  <= '0;
            ign_q   <= 1'b0;
            state_q <= S_VSEL;
          end
        end
        S_VSEL: state_q <= S_VREAD;
        S_VREAD: begin
          vtag_q  <= vic_tag;
          vdata_q <= vic_data;
          state_q <= (vic_v && vic_d) ? S_WB : S_RREQ;
        end
        S_WB:   if (wr_rdy) state_q <= S_RREQ;
        S_RREQ: if (rd_rdy) state_q <= S_RECV;
        S_RECV: begin
          if (ret_valid) begin
            buf_q[beat_q] <= ret_data;
            beat_q        <= beat_q + BW'(1);
            if (ret_last || beat_q == BW'(LINE_WORDS - 1)) begin
              if (!(ret_last && beat_q == BW'(LINE_WORDS - 1))) begin
                err_q <= 1'b1;
              end
              state_q <= S_FILL;
            end
          end
        end
        S_FILL:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign miss_ready = (state_q == S_IDLE);
  assign vic_rd_en  = (state_q == S_VSEL);
  assign wr_req     = (state_q == S_WB);
  assign rd_req     = (state_q == S_RREQ);
  assign fill_we    = (state_q == S_FILL);
  assign done       = fill_we;
  assign err        = err_q;

  assign vic_way   = vic_rd_en ? way_q : '0;
  assign vic_idx   = vic_rd_en ? idx_q : '0;
  assign wr_addr   = wr_req ? {vtag_q, idx_q, {OFFLEN{1'b0}}} : '0;
  assign wr_data   = wr_req ? vdata_q : '0;
  assign rd_addr   = rd_req ? {tag_q, idx_q, {OFFLEN{1'b0}}} : '0;
  assign fill_way  = fill_we ? way_q : '0;
  assign fill_idx  = fill_we ? idx_q : '0;
  assign fill_tag  = fill_we ? tag_q : '0;
  assign fill_data = fill_we ? buf_q : '0;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench: cycle-level reference model for the round-robin
// configuration plus a transaction-level LFSR check for a 4-way/8-word build.
module tb_cache_miss_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT0: WAY=2, LINE_WORDS=4, round-robin ----------------
  logic         resetn, miss_valid, miss_ready, vic_rd_en, vic_v, vic_d;
  logic [7:0]   miss_idx, vic_idx, fill_idx;
  logic [19:0]  miss_tag, vic_tag, fill_tag;
  logic [0:0]   vic_way, fill_way;
  logic [127:0] vic_data, wr_data, fill_data;
  logic         wr_req, wr_rdy, rd_req, rd_rdy, ret_valid, ret_last, fill_we, done, err;
  logic [31:0]  wr_addr, rd_addr, ret_data;

  cache_miss_ctrl #(.WAY(2), .LINE_WORDS(4), .INDEXLEN(8), .TAGLEN(20), .REPL_MODE(0)) dut0 (
    .clk(clk), .resetn(resetn), .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_idx(miss_idx), .miss_tag(miss_tag), .vic_rd_en(vic_rd_en), .vic_way(vic_way),
    .vic_idx(vic_idx), .vic_v(vic_v), .vic_d(vic_d), .vic_tag(vic_tag), .vic_data(vic_data),
    .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data), .fill_we(fill_we), .fill_way(fill_way),
    .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data), .done(done), .err(err));

  // ---------------- DUT1: WAY=4, LINE_WORDS=8, LFSR ----------------
  logic         resetn1, miss_valid1, miss_ready1, vic_rd_en1, vic_v1, vic_d1;
  logic [7:0]   miss_idx1, vic_idx1, fill_idx1;
  logic [18:0]  miss_tag1, vic_tag1, fill_tag1;
  logic [1:0]   vic_way1, fill_way1;
  logic [255:0] vic_data1, wr_data1, fill_data1;
  logic         wr_req1, wr_rdy1, rd_req1, rd_rdy1, ret_valid1, ret_last1, fill_we1, done1, err1;
  logic [31:0]  wr_addr1, rd_addr1, ret_data1;

  cache_miss_ctrl #(.WAY(4), .LINE_WORDS(8), .INDEXLEN(8), .TAGLEN(19), .REPL_MODE(1)) dut1 (
    .clk(clk), .resetn(resetn1), .miss_valid(miss_valid1), .miss_ready(miss_ready1),
    .miss_idx(miss_idx1), .miss_tag(miss_tag1), .vic_rd_en(vic_rd_en1), .vic_way(vic_way1),
    .vic_idx(vic_idx1), .vic_v(vic_v1), .vic_d(vic_d1), .vic_tag(vic_tag1), .vic_data(vic_data1),
    .wr_req(wr_req1), .wr_rdy(wr_rdy1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_req(rd_req1), .rd_rdy(rd_rdy1), .rd_addr(rd_addr1), .ret_valid(ret_valid1),
    .ret_last(ret_last1), .ret_data(ret_data1), .fill_we(fill_we1), .fill_way(fill_way1),
    .fill_idx(fill_idx1), .fill_tag(fill_tag1), .fill_data(fill_data1), .done(done1), .err(err1));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    tests++;
    fails++;
    $display("FAIL timeout %s: got no response expected response within bound at %0t", what, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT0 reference model (miss lifecycle by phase) ----------------
  // phase: 0 idle, 1 victim read strobe, 2 victim data, 3 writeback, 4 read req, 5 receive, 6 fill
  int          ph;
  bit          mvalid = 1'b0;
  logic [7:0]  m_idx;
  logic [19:0] m_tag, m_vtag;
  int          m_way, m_beat;
  logic [127:0] m_vdata;
  logic [31:0] m_line [4];
  bit          m_err, m_ign;
  int          rr [256];

  always @(negedge clk) begin
    if (mvalid) begin
      chk("miss_ready", miss_ready, ph == 0);
      chk("vic_rd_en", vic_rd_en, ph == 1);
      chk("vic_way", vic_way, (ph == 1) ? m_way : 0);
      chk("vic_idx", vic_idx, (ph == 1) ? m_idx : 0);
      chk("wr_req", wr_req, ph == 3);
      chk("wr_addr", wr_addr, (ph == 3) ? {m_vtag, m_idx, 4'h0} : 0);
      chk("wr_data", wr_data, (ph == 3) ? m_vdata : 0);
      chk("rd_req", rd_req, ph == 4);
      chk("rd_addr", rd_addr, (ph == 4) ? {m_tag, m_idx, 4'h0} : 0);
      chk("fill_we", fill_we, ph == 6);
      chk("done", done, ph == 6);
      chk("fill_way", fill_way, (ph == 6) ? m_way : 0);
      chk("fill_idx", fill_idx, (ph == 6) ? m_idx : 0);
      chk("fill_tag", fill_tag, (ph == 6) ? m_tag : 0);
      chk("fill_data", fill_data,
          (ph == 6) ? {m_line[3], m_line[2], m_line[1], m_line[0]} : 128'h0);
      chk("err", err, m_err);
    end
    if (!resetn) begin
      ph = 0; m_idx = '0; m_tag = '0; m_vtag = '0; m_way = 0; m_beat = 0;
      m_vdata = '0; m_err = 0; m_ign = 1;
      for (int i = 0; i < 4; i++) m_line[i] = '0;
      for (int i = 0; i < 256; i++) rr[i] = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (ret_valid && ph != 5 && !m_ign) m_err = 1;
      case (ph)
        0: if (miss_valid) begin
             m_idx = miss_idx; m_tag = miss_tag; m_way = rr[miss_idx];
             m_beat = 0; m_ign = 0; ph = 1;
           end
        1: ph = 2;
        2: if (vic_v && vic_d) begin m_vtag = vic_tag; m_vdata = vic_data; ph = 3; end
           else ph = 4;
        3: if (wr_rdy) ph = 4;
        4: if (rd_rdy) ph = 5;
        5: if (ret_valid) begin
             m_line[m_beat] = ret_data;
             if (ret_last || m_beat == 3) begin
               if (!(ret_last && m_beat == 3)) m_err = 1;
               ph = 6;
             end
             m_beat = (m_beat + 1) % 4;
           end
        6: begin rr[m_idx] = (rr[m_idx] + 1) % 2; ph = 0; end
        default: ph = 0;
      endcase
    end
  end

  // ---------------- DUT1 LFSR model ----------------
  logic [15:0] l1;
  bit          l1v = 1'b0;
  int          exp_way1 [$];

  always @(negedge clk) begin
    if (!resetn1) begin
      l1 = 16'h0001; l1v = 1'b1;
    end else if (l1v) begin
      if (miss_valid1) exp_way1.push_back(int'(l1 % 4));
      l1 = {l1[14:0], l1[15] ^ l1[13] ^ l1[12] ^ l1[10]};
    end
  end

  task automatic do_miss(input logic [7:0] idx, input logic [19:0] tag, input bit vv, input bit vd,
                         input logic [19:0] vtag, input int wdly, input int rdly, input int nbeats,
                         input bit last, input bit seq_data, input bit junk,
                         output logic [31:0] o_wr_addr, output logic [31:0] o_rd_addr,
                         output int o_wr_cyc, output int o_way, output logic [127:0] o_data);
    int n;
    vic_v = vv; vic_d = vd; vic_tag = vtag;
    vic_data = {$urandom, $urandom, $urandom, $urandom};
    miss_valid = 1; miss_idx = idx; miss_tag = tag;
    tick;
    if (junk) begin miss_idx = 8'($urandom); miss_tag = 20'($urandom); end
    else miss_valid = 0;
    o_wr_cyc = 0; o_wr_addr = '0; o_rd_addr = '0; o_way = -1; o_data = '0;
    if (vv && vd) begin
      n = 0;
      while (!wr_req && n < 10) begin tick; n++; end
      if (!wr_req) timeout("wr_req");
      o_wr_addr = wr_addr;
      repeat (wdly) begin if (wr_req) o_wr_cyc++; tick; end
      wr_rdy = 1; if (wr_req) o_wr_cyc++; tick; wr_rdy = 0;
    end
    n = 0;
    while (!rd_req && n < 10) begin tick; n++; end
    if (!rd_req) timeout("rd_req");
    o_rd_addr = rd_addr;
    repeat (rdly) tick;
    rd_rdy = 1; tick; rd_rdy = 0;
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 2) == 0) tick;
      ret_valid = 1;
      ret_data  = seq_data ? 32'(b + 1) : $urandom;
      ret_last  = last && (b == nbeats - 1);
      tick;
      ret_valid = 0; ret_last = 0;
    end
    n = 0;
    while (!done && n < 20) begin tick; n++; end
    if (!done) timeout("done");
    o_way = int'(fill_way); o_data = fill_data;
    miss_valid = 0;
    tick;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic do_miss1(input bit first);
    int n;
    logic [7:0]   idx;
    logic [18:0]  tag;
    logic [255:0] line;
    idx = 8'($urandom); tag = 19'($urandom);
    miss_valid1 = 1; miss_idx1 = idx; miss_tag1 = tag;
    tick;
    miss_valid1 = 0;
    n = 0;
    while (!rd_req1 && n < 10) begin tick; n++; end
    if (!rd_req1) timeout("rd_req1");
    chk("lfsr_rd_addr", rd_addr1, {tag, idx, 5'h0});
    tick;
    line = '0;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(0, 3) == 0) tick;
      ret_valid1 = 1; ret_data1 = $urandom; ret_last1 = (b == 7);
      line[b*32 +: 32] = ret_data1;
      tick;
      ret_valid1 = 0; ret_last1 = 0;
    end
    n = 0;
    while (!done1 && n < 20) begin tick; n++; end
    if (!done1) timeout("done1");
    if (exp_way1.size() == 0) timeout("lfsr_accept");
    else chk("lfsr_fill_way", fill_way1, exp_way1.pop_front());
    if (first) chk("lfsr_first_way", fill_way1, 2'd1);
    chk("lfsr_fill_data", fill_data1, line);
    chk("lfsr_fill_idx", fill_idx1, idx);
    chk("lfsr_fill_tag", fill_tag1, tag);
    chk("lfsr_fill_we", fill_we1, 1);
    chk("lfsr_miss_ready_busy", miss_ready1, 0);
    chk("lfsr_idle_outs", {vic_rd_en1, vic_way1, vic_idx1, wr_req1, wr_addr1, rd_req1, rd_addr1}, 0);
    chk("lfsr_wr_data", wr_data1, 0);
    chk("lfsr_err", err1, 0);
    tick;
    chk("lfsr_done_one_cycle", done1, 0);
  endtask

  initial begin
    logic [31:0]  wa, ra;
    logic [127:0] fd;
    int           wc, wy;
    resetn = 0; miss_valid = 0; miss_idx = '0; miss_tag = '0; vic_v = 0; vic_d = 0;
    vic_tag = '0; vic_data = '0; wr_rdy = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = '0;
    resetn1 = 0; miss_valid1 = 0; miss_idx1 = '0; miss_tag1 = '0; vic_v1 = 0; vic_d1 = 0;
    vic_tag1 = '0; vic_data1 = '0; wr_rdy1 = 1; rd_rdy1 = 1; ret_valid1 = 0; ret_last1 = 0;
    ret_data1 = '0;
    repeat (3) tick;
    resetn = 1;
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_outs", {vic_rd_en, wr_req, rd_req, fill_we, done, err, fill_data}, 0);

    // clean miss, sequential beats
    do_miss(8'h12, 20'hABCDE, 0, 0, '0, 0, 0, 4, 1, 1, 0, wa, ra, wc, wy, fd);
    chk("clean_rd_addr", ra, 32'hABCDE120);
    chk("clean_fill_way", wy, 0);
    chk("clean_fill_data", fd, 128'h00000004_00000003_00000002_00000001);

    // dirty victim, wr_rdy held off three cycles
    do_miss(8'h12, 20'h5A5A5, 1, 1, 20'h11111, 3, 1, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("dirty_wr_addr", wa, 32'h11111120);
    chk("dirty_wr_cycles", wc, 4);
    chk("dirty_fill_way", wy, 1);

    // round-robin on a fresh set, back-to-back, with miss_valid held while busy
    do_miss(8'h05, 20'h00001, 0, 0, '0, 0, 0, 4, 1, 0, 1, wa, ra, wc, wy, fd);
    chk("rr_way_a", wy, 0);
    do_miss(8'h05, 20'h00002, 0, 0, '0, 0, 0, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("rr_way_b", wy, 1);
    do_miss(8'h05, 20'h00003, 0, 0, '0, 0, 0, 4, 1, 0, 1, wa, ra, wc, wy, fd);
    chk("rr_way_c", wy, 0);
    do_miss(8'h06, 20'h00004, 0, 0, '0, 0, 0, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("rr_way_other_set", wy, 0);

    for (int i = 0; i < 20; i++) begin
      do_miss(8'($urandom_range(0, 3)), 20'($urandom), 1'($urandom), 1'($urandom), 20'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), 4, 1, 0, 1'($urandom),
              wa, ra, wc, wy, fd);
    end

    // early ret_last on beat 2
    do_miss(8'h30, 20'h0BEEF, 0, 0, '0, 0, 0, 2, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("early_last_err", err, 1);
    do_miss(8'h31, 20'h0CAFE, 1, 1, 20'h22222, 0, 0, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("err_sticky", err, 1);

    // reset in RECV after two beats, stray beats afterwards
    miss_valid = 1; miss_idx = 8'h07; miss_tag = 20'h77777; vic_v = 0;
    tick;
    miss_valid = 0;
    begin
      int n = 0;
      while (!rd_req && n < 10) begin tick; n++; end
      if (!rd_req) timeout("abort_rd_req");
    end
    rd_rdy = 1; tick; rd_rdy = 0;
    repeat (2) begin ret_valid = 1; ret_data = $urandom; tick; end
    resetn = 0; tick; resetn = 1;
    chk("abort_idle", miss_ready, 1);
    chk("abort_no_fill", fill_we, 0);
    ret_data = $urandom; tick;
    ret_last = 1; tick;
    ret_valid = 0; ret_last = 0;
    chk("abort_err_clear", err, 0);
    do_miss(8'h07, 20'h12345, 0, 0, '0, 0, 0, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("post_abort_err", err, 0);
    chk("post_abort_way", wy, 0);

    // ret_valid at the final beat without ret_last
    do_miss(8'h08, 20'h54321, 0, 0, '0, 0, 0, 4, 0, 0, 0, wa, ra, wc, wy, fd);
    chk("missing_last_err", err, 1);

    // stray beat while idle after a miss has been accepted
    resetn = 0; tick; resetn = 1;
    ret_valid = 1; tick; ret_valid = 0;
    chk("stray_after_reset", err, 0);
    do_miss(8'h09, 20'h0F0F0, 0, 0, '0, 0, 0, 4, 1, 0, 0, wa, ra, wc, wy, fd);
    chk("stray_pre_err", err, 0);
    ret_valid = 1; tick; ret_valid = 0;
    chk("stray_idle_err", err, 1);

    // LFSR build: release reset with a miss already waiting
    tick;
    resetn1 = 1;
    for (int i = 0; i < 8; i++) do_miss1(i == 0);
    chk("lfsr_all_consumed", exp_way1.size(), 0);

    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameters SHALL be: WAY, default 2, ways per set (power of 2, >=2); LINE_WORDS, default 4, 32-bit words per line (power of 2); INDEXLEN, default 8, set-index bits; TAGLEN, default 20, tag bits; REPL_MODE, default 0, 0=per-set round-robin, 1=LFSR.
REQ-002 Constraint SHALL hold: TAGLEN+INDEXLEN+OFFLEN=32, OFFLEN=log2(LINE_WORDS*4); WB=log2(WAY).
REQ-003 Ports (name dir width meaning) SHALL be: clk in 1 clock; resetn in 1 reset, synchronous, active-low.
REQ-004 miss_valid in 1 miss request; miss_ready out 1 accept; miss_idx in INDEXLEN; miss_tag in TAGLEN.
REQ-005 vic_rd_en out 1 victim tag/V/D/data read strobe; vic_way out WB; vic_idx out INDEXLEN.
REQ-006 vic_v in 1, vic_d in 1, vic_tag in TAGLEN, vic_data in 32*LINE_WORDS; valid the cycle after vic_rd_en.
REQ-007 wr_req out 1; wr_rdy in 1; wr_addr out 32; wr_data out 32*LINE_WORDS (dirty victim writeback).
REQ-008 rd_req out 1; rd_rdy in 1; rd_addr out 32; ret_valid in 1; ret_last in 1; ret_data in 32.
REQ-009 fill_we out 1; fill_way out WB; fill_idx out INDEXLEN; fill_tag out TAGLEN; fill_data out 32*LINE_WORDS.
REQ-010 done out 1 completion pulse; err out 1 sticky protocol-error flag.

Function
REQ-011 FSM states SHALL be IDLE, VSEL, VREAD, WB, RREQ, RECV, FILL.
REQ-012 IDLE: miss_ready=1; miss_valid=1 latches idx/tag, chooses victim way, -> VSEL.
REQ-013 VSEL: vic_rd_en=1 for exactly one cycle with latched way/idx; -> VREAD.
REQ-014 VREAD: samples vic_*; vic_v&vic_d -> WB, else -> RREQ.
REQ-015 WB: wr_req=1, wr_addr={vic_tag,idx,OFFLEN'b0}, wr_data=sampled vic_data, held stable until wr_rdy=1; transfer in that cycle; -> RREQ.
REQ-016 RREQ: rd_req=1, rd_addr={miss_tag,idx,OFFLEN'b0}, held until rd_rdy=1; -> RECV.
REQ-017 RECV: each ret_valid beat writes ret_data to word[beat_cnt] of line buffer, beat_cnt increments (width log2(LINE_WORDS), wraps); word 0 at bits [31:0].
REQ-018 ret_valid&ret_last with beat_cnt==LINE_WORDS-1 -> FILL; ret_last early, or ret_valid without ret_last at beat LINE_WORDS-1, SHALL set err and still -> FILL (missing words keep stale buffer values).
REQ-019 FILL: fill_we=1 and done=1 for exactly one cycle; fill_way/idx/tag = latched values, fill_data = line buffer; -> IDLE.
REQ-020 Round-robin (REPL_MODE=0): per-set WB-bit counter, victim=counter[miss_idx], counter[idx] increments (wraps WAY-1->0) in FILL only.
REQ-021 LFSR (REPL_MODE=1): 16-bit Fibonacci, taps 16,14,13,11, steps every cycle; victim=LFSR[WB-1:0] sampled on IDLE accept.
REQ-022 miss_valid outside IDLE SHALL be ignored (miss_ready=0); one miss in flight.
REQ-023 ret_valid outside RECV SHALL be ignored and set err.
REQ-024 Back-to-back: miss_valid in the cycle after FILL SHALL be accepted (IDLE entered; no bubble beyond that).
REQ-025 Outputs vic_*, wr_*, rd_*, fill_*, done SHALL be 0 whenever not driven by their state; all outputs registered or decoded from state only.

Reset
REQ-026 resetn=0 at a clk edge: state=IDLE, beat_cnt=0, all RR counters=0, LFSR=16'h0001, err=0, line buffer and latches=0.
REQ-027 Reset mid-operation SHALL abort immediately: no further wr_req/rd_req/fill_we; outstanding bus beats after reset ignored without err until next accepted miss.
REQ-028 Reset outputs: miss_ready=1 first cycle after reset release, all others 0.

Structure
REQ-029 State encoding, OFFLEN/WB derivation and address-composition constants SHALL live in shared cache.vh.
REQ-030 Replacement logic SHALL be one sub-module cache_victim_sel (RR array + LFSR, mode-selected) with ports clk, resetn, idx, adv, way.

Verification
REQ-031 Clean miss: idx=8'h12, tag=20'hABCDE, vic_v=0 -> rd_addr=32'hABCDE120, 4 beats 1..4 -> fill_data=128'h4_3_2_1 words, fill_way=0, done 1 cycle.
REQ-032 Dirty victim: vic_v=1,vic_d=1,vic_tag=20'h11111, wr_rdy delayed 3 cycles -> wr_req held 4 cycles, wr_addr=32'h11111120, then rd_req.
REQ-033 Round-robin: three misses to idx 5, WAY=2 -> fill_way 0,1,0; miss to idx 6 -> way 0.
REQ-034 Early ret_last on beat 2 of 4 -> err=1, FILL still occurs, err stays 1 until reset.
REQ-035 resetn=0 in RECV after 2 beats -> next cycle IDLE, no fill_we; new miss completes normally with err=0.
REQ-036 WAY=4, LINE_WORDS=8, REPL_MODE=1: 8 misses -> all fill_way match LFSR model, 8 beats each, done per miss.
